// File: rtl/eth_tx_arbiter.sv
// ============================================================================
//  Module      : eth_tx_arbiter
//  Description : Two-source (ARP / UDP) GMII transmit arbiter. It grants in
//                round-robin order, registers the granted stream onto the
//                merged GMII output and inserts an inter-frame gap. A per-grant
//                watchdog cuts off frames that exceed MAX_FRAME cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_arbiter #(
   parameter int IFG_CYCLES = 12,    // idle cycles after every frame (>= 1)
   parameter int MAX_FRAME  = 1600   // watchdog limit in granted cycles
) (
   input  logic       gmii_tx_clk,
   input  logic       rst,
   input  logic       arp_req,
   output logic       arp_gnt,
   input  logic       arp_tx_en,
   input  logic [7:0] arp_txd,
   input  logic       udp_req,
   output logic       udp_gnt,
   input  logic       udp_tx_en,
   input  logic [7:0] udp_txd,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       busy,
   output logic       timeout_err
);

   localparam int c_WD_W  = $clog2(MAX_FRAME + 1);
   localparam int c_IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

   // The watchdog fires on the edge at which the counter would reach MAX_FRAME,
   // so a grant lasts at most MAX_FRAME cycles.
   localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(MAX_FRAME - 1);
   localparam logic [c_IFG_W-1:0] c_IFG_LAST = c_IFG_W'(IFG_CYCLES - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_ARP  = 2'd1;
   localparam logic [1:0] c_S_UDP  = 2'd2;
   localparam logic [1:0] c_S_IFG  = 2'd3;

   logic [1:0]         state_q,    state_d;
   logic [c_WD_W-1:0]  wd_cnt_q,   wd_cnt_d;
   logic [c_IFG_W-1:0] ifg_cnt_q,  ifg_cnt_d;
   logic               last_udp_q, last_udp_d;   // 1: UDP was served last
   logic               started_q,  started_d;    // granted tx_en seen this grant
   logic               tx_en_q,    tx_en_d;
   logic [7:0]         txd_q,      txd_d;
   logic               tout_q,     tout_d;

   logic               w_granted;
   logic               w_sel_udp;
   logic               w_req;
   logic               w_en;
   logic [7:0]         w_txd;
   logic               w_frame_end;
   logic               w_timeout;
   logic               w_abandon;

   // Only the granted source is looked at; the other one is masked off here.
   assign w_granted   = (state_q == c_S_ARP) || (state_q == c_S_UDP);
   assign w_sel_udp   = (state_q == c_S_UDP);
   assign w_req       = w_sel_udp ? udp_req : arp_req;
   assign w_en        = w_granted & (w_sel_udp ? udp_tx_en : arp_tx_en);
   assign w_txd       = w_granted ? (w_sel_udp ? udp_txd : arp_txd) : 8'h00;
   // tx_en_q is the previous granted tx_en, so a falling edge marks frame end.
   assign w_frame_end = w_granted & tx_en_q & ~w_en;
   assign w_timeout   = w_granted & (wd_cnt_q == c_WD_LAST);
   assign w_abandon   = w_granted & ~w_req & ~started_q & ~w_en;

   // Next-state, counter and output-mux logic.
   always_comb begin
      state_d    = state_q;
      wd_cnt_d   = '0;
      ifg_cnt_d  = '0;
      last_udp_d = last_udp_q;
      started_d  = 1'b0;
      tout_d     = 1'b0;
      tx_en_d    = w_en & ~w_timeout;
      txd_d      = w_timeout ? 8'h00 : w_txd;

      case (state_q)
         c_S_IDLE: begin
            if (arp_req && udp_req) begin
               state_d = last_udp_q ? c_S_ARP : c_S_UDP;
            end else if (arp_req) begin
               state_d = c_S_ARP;
            end else if (udp_req) begin
               state_d = c_S_UDP;
            end
         end
         c_S_ARP, c_S_UDP: begin
            wd_cnt_d  = wd_cnt_q + 1'b1;
            started_d = started_q | w_en;
            if (w_timeout) begin
               state_d    = c_S_IFG;
               tout_d     = 1'b1;
               last_udp_d = w_sel_udp;
            end else if (w_frame_end) begin
               state_d    = c_S_IFG;
               last_udp_d = w_sel_udp;
            end else if (w_abandon) begin
               // Nothing was sent, so the turn is not consumed.
               state_d = c_S_IDLE;
            end
         end
         c_S_IFG: begin
            if (ifg_cnt_q == c_IFG_LAST) begin
               state_d = c_S_IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = c_S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge gmii_tx_clk) begin
      if (rst) begin
         state_q    <= c_S_IDLE;
         wd_cnt_q   <= '0;
         ifg_cnt_q  <= '0;
         last_udp_q <= 1'b1;
         started_q  <= 1'b0;
         tx_en_q    <= 1'b0;
         txd_q      <= 8'h00;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wd_cnt_q   <= wd_cnt_d;
         ifg_cnt_q  <= ifg_cnt_d;
         last_udp_q <= last_udp_d;
         started_q  <= started_d;
         tx_en_q    <= tx_en_d;
         txd_q      <= txd_d;
         tout_q     <= tout_d;
      end
   end

   assign arp_gnt     = (state_q == c_S_ARP);
   assign udp_gnt     = (state_q == c_S_UDP);
   assign busy        = (state_q != c_S_IDLE);
   assign gmii_tx_en  = tx_en_q;
   assign gmii_txd    = txd_q;
   assign timeout_err = tout_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
// ============================================================================
//  Module      : tb_eth_tx_arbiter
//  Description : Directed self-checking bench for eth_tx_arbiter
//                (IFG_CYCLES = 12, MAX_FRAME = 100).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_tx_arbiter;

   logic       clk;
   logic       rst;
   logic       arp_req, arp_gnt, arp_tx_en;
   logic [7:0] arp_txd;
   logic       udp_req, udp_gnt, udp_tx_en;
   logic [7:0] udp_txd;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic       busy, timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   int low_run  = 0;
   int last_gap = 0;

   eth_tx_arbiter #(
      .IFG_CYCLES (12),
      .MAX_FRAME  (100)
   ) u_dut (
      .gmii_tx_clk (clk),
      .rst         (rst),
      .arp_req     (arp_req),
      .arp_gnt     (arp_gnt),
      .arp_tx_en   (arp_tx_en),
      .arp_txd     (arp_txd),
      .udp_req     (udp_req),
      .udp_gnt     (udp_gnt),
      .udp_tx_en   (udp_tx_en),
      .udp_txd     (udp_txd),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Length of the most recent run of low gmii_tx_en preceding a frame.
   always @(negedge clk) begin
      if (gmii_tx_en) begin
         if (low_run != 0) last_gap = low_run;
         low_run = 0;
      end else begin
         low_run = low_run + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends nbytes starting in the current (granted) cycle, drops req at byte
   // drop_at and at the end, and returns in the first IFG cycle.
   task automatic send_frame(input bit is_udp, input int nbytes, input int drop_at,
                             input logic [7:0] base, input string tag);
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         b = base + 8'(i);
         if (is_udp) begin
            udp_tx_en = 1'b1; udp_txd = b;
            if (i == drop_at) udp_req = 1'b0;
         end else begin
            arp_tx_en = 1'b1; arp_txd = b;
            if (i == drop_at) arp_req = 1'b0;
         end
         tick();
         check({tag, "_en"},  32'(gmii_tx_en), 32'd1);
         check({tag, "_txd"}, 32'(gmii_txd), 32'(b));
      end
      if (is_udp) begin
         udp_tx_en = 1'b0; udp_txd = 8'h00; udp_req = 1'b0;
      end else begin
         arp_tx_en = 1'b0; arp_txd = 8'h00; arp_req = 1'b0;
      end
      check({tag, "_hold"}, 32'(is_udp ? udp_gnt : arp_gnt), 32'd1);
      tick();
      check({tag, "_ifg_busy"}, 32'(busy), 32'd1);
      check({tag, "_ifg_gnt"},  32'({arp_gnt, udp_gnt}), 32'd0);
      check({tag, "_ifg_en"},   32'(gmii_tx_en), 32'd0);
   endtask

   // From the first IFG cycle: 11 more IFG cycles, then IDLE.
   task automatic ifg_to_idle(input string tag);
      repeat (11) tick();
      check({tag, "_ifg_last"}, 32'(busy), 32'd1);
      tick();
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      arp_req = 1'b0; arp_tx_en = 1'b0; arp_txd = 8'h00;
      udp_req = 1'b0; udp_tx_en = 1'b0; udp_txd = 8'h00;
      tick(); tick();
      check("rst_arp_gnt", 32'(arp_gnt), 32'd0);
      check("rst_udp_gnt", 32'(udp_gnt), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_en",      32'(gmii_tx_en), 32'd0);
      check("rst_txd",     32'(gmii_txd), 32'd0);
      check("rst_tout",    32'(timeout_err), 32'd0);

      // Single ARP frame: req at cycle 0, tx_en cycles 2..61, req dropped mid-frame.
      rst = 1'b0;
      arp_req = 1'b1;
      tick();
      check("t1_arp_gnt_c1", 32'(arp_gnt), 32'd1);
      check("t1_udp_gnt_c1", 32'(udp_gnt), 32'd0);
      tick();
      check("t1_en_c2", 32'(gmii_tx_en), 32'd0);
      send_frame(1'b0, 60, 10, 8'h10, "t1");
      ifg_to_idle("t1");

      // Ties after reset: ARP, then UDP, then ARP again; other source drives noise.
      pulse_reset();
      arp_req = 1'b1; udp_req = 1'b1; udp_tx_en = 1'b1; udp_txd = 8'hEE;
      tick();
      check("tie1_arp", 32'(arp_gnt), 32'd1);
      check("tie1_udp", 32'(udp_gnt), 32'd0);
      send_frame(1'b0, 8, -1, 8'h20, "tie_arp");
      udp_tx_en = 1'b0; udp_txd = 8'h00;
      ifg_to_idle("tie_arp");
      tick();
      check("tie2_udp", 32'(udp_gnt), 32'd1);
      check("tie2_arp", 32'(arp_gnt), 32'd0);
      arp_req = 1'b1; arp_tx_en = 1'b1; arp_txd = 8'hEE;
      send_frame(1'b1, 6, -1, 8'h80, "tie_udp");
      check("b2b_gap", 32'(last_gap), 32'd14);
      arp_tx_en = 1'b0; arp_txd = 8'h00; udp_req = 1'b1;
      ifg_to_idle("tie_udp");
      tick();
      check("tie3_arp", 32'(arp_gnt), 32'd1);
      check("tie3_udp", 32'(udp_gnt), 32'd0);
      arp_req = 1'b0; udp_req = 1'b0;
      tick();
      check("tie3_abandon", 32'(busy), 32'd0);

      // Abandoned request after reset: no IFG, last-served stays UDP.
      pulse_reset();
      arp_req = 1'b1;
      tick();
      check("ab_gnt", 32'(arp_gnt), 32'd1);
      arp_req = 1'b0;
      tick();
      check("ab_idle_busy", 32'(busy), 32'd0);
      check("ab_idle_gnt",  32'(arp_gnt), 32'd0);
      arp_req = 1'b1; udp_req = 1'b1;
      tick();
      check("ab_tie_arp", 32'(arp_gnt), 32'd1);
      arp_req = 1'b0; udp_req = 1'b0;
      tick();
      check("ab_tie_idle", 32'(busy), 32'd0);

      // Watchdog: UDP tx_en stuck high.
      udp_req = 1'b1;
      tick();
      check("wd_gnt", 32'(udp_gnt), 32'd1);
      udp_tx_en = 1'b1; udp_txd = 8'h55;
      repeat (99) tick();
      check("wd_pre_tout", 32'(timeout_err), 32'd0);
      check("wd_pre_en",   32'(gmii_tx_en), 32'd1);
      check("wd_pre_gnt",  32'(udp_gnt), 32'd1);
      tick();
      check("wd_tout",    32'(timeout_err), 32'd1);
      check("wd_en_drop", 32'(gmii_tx_en), 32'd0);
      check("wd_gnt_off", 32'(udp_gnt), 32'd0);
      check("wd_busy",    32'(busy), 32'd1);
      udp_req = 1'b0; udp_tx_en = 1'b0; udp_txd = 8'h00;
      tick();
      check("wd_tout_pulse", 32'(timeout_err), 32'd0);
      repeat (10) tick();
      check("wd_ifg_last", 32'(busy), 32'd1);
      tick();
      check("wd_idle", 32'(busy), 32'd0);

      // Reset at byte 20 of a 64-byte ARP frame, then a fresh ARP frame.
      arp_req = 1'b1;
      tick();
      check("rm_gnt", 32'(arp_gnt), 32'd1);
      for (int i = 0; i < 20; i++) begin
         arp_tx_en = 1'b1; arp_txd = 8'h40 + 8'(i);
         tick();
      end
      check("rm_byte19", 32'(gmii_txd), 32'h53);
      arp_txd = 8'h54;
      rst = 1'b1;
      tick();
      check("rm_en",   32'(gmii_tx_en), 32'd0);
      check("rm_txd",  32'(gmii_txd), 32'd0);
      check("rm_gnt0", 32'(arp_gnt), 32'd0);
      check("rm_busy", 32'(busy), 32'd0);
      rst = 1'b0; arp_tx_en = 1'b0; arp_txd = 8'h00;
      tick();
      check("rm_regrant", 32'(arp_gnt), 32'd1);
      send_frame(1'b0, 3, -1, 8'h60, "rm_new");
      ifg_to_idle("rm_new");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
